// File: rtl/timer_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : timer_tick_scheduler
// Description : Sole bus master of a 16-bit interval timer. Programs it as a
//               continuous, interrupting base-tick source, then shares each
//               base tick among NUM_CH independent one-shot tick counters.
// Ports       : clk, reset_n          - clock, asynchronous active-low reset
//               ch_start/ch_cancel    - per-channel control pulses
//               ch_load               - per-channel tick count (slice i = ch i)
//               ch_active/ch_expired  - per-channel status / expiry pulse
//               ready                 - timer initialisation complete
//               tick_count            - serviced base ticks (wraps)
//               tmr_*                 - timer slave write port and irq input
// Revision    : 1.0 - initial release
// ============================================================================
module timer_tick_scheduler #(
    parameter int              NUM_CH      = 4,
    parameter int              CNT_W       = 16,
    parameter longint unsigned TICK_PERIOD = 64'd50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_cancel,
    input  logic [NUM_CH*CNT_W-1:0] ch_load,
    output logic [NUM_CH-1:0]       ch_active,
    output logic [NUM_CH-1:0]       ch_expired,
    output logic                    ready,
    output logic [31:0]             tick_count,
    output logic [2:0]              tmr_address,
    output logic                    tmr_chipselect,
    output logic                    tmr_write_n,
    output logic [15:0]             tmr_writedata,
    input  logic                    tmr_irq
);

    localparam logic [31:0] C_PERIOD_M1 = 32'(TICK_PERIOD - 64'd1);

    typedef enum logic [2:0] {
        INIT_PL  = 3'd0,
        INIT_PH  = 3'd1,
        INIT_CTL = 3'd2,
        IDLE     = 3'd3,
        ACK      = 3'd4,
        TICK     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic [31:0]         tick_q, tick_d;
    logic [NUM_CH-1:0]   active_q, active_d;
    logic [NUM_CH-1:0]   expired_q, expired_d;
    logic [CNT_W-1:0]    count_q [NUM_CH];
    logic [CNT_W-1:0]    count_d [NUM_CH];

    // The bus write for a state is computed in that state and registered, so
    // it appears on the bus during the following cycle. The ACK write is
    // therefore launched from IDLE and is on the bus while the FSM is in ACK.
    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'd0;
        case (state_q)
            INIT_PL: begin
                state_d = INIT_PH;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd2;
                wdata_d = C_PERIOD_M1[15:0];
            end
            INIT_PH: begin
                state_d = INIT_CTL;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd3;
                wdata_d = C_PERIOD_M1[31:16];
            end
            INIT_CTL: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd1;
                wdata_d = 16'h0007;   // ITO | CONT | START
            end
            IDLE: begin
                if (tmr_irq) begin
                    state_d = ACK;
                    cs_d    = 1'b1;   // status write clears the timeout flag
                    wn_d    = 1'b0;
                end
            end
            ACK:     state_d = TICK;
            TICK:    state_d = IDLE;
            default: state_d = INIT_PL;
        endcase
    end

    // Reaching IDLE means the control write is on the bus now, so ready
    // rises one cycle after that write.
    always_comb begin
        ready_d = ready_q | (state_q == IDLE);
        tick_d  = (state_q == TICK) ? tick_q + 32'd1 : tick_q;
    end

    // Per-channel priority: start, then cancel, then tick service.
    always_comb begin
        active_d  = active_q;
        expired_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            if (ch_start[i]) begin
                if (ch_load[i*CNT_W +: CNT_W] != '0) begin
                    count_d[i]  = ch_load[i*CNT_W +: CNT_W];
                    active_d[i] = 1'b1;
                end else begin
                    count_d[i]   = '0;
                    active_d[i]  = 1'b0;
                    expired_d[i] = 1'b1;
                end
            end else if (ch_cancel[i]) begin
                count_d[i]  = '0;
                active_d[i] = 1'b0;
            end else if (state_q == TICK && active_q[i]) begin
                if (count_q[i] == CNT_W'(1)) begin
                    count_d[i]   = '0;
                    active_d[i]  = 1'b0;
                    expired_d[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT_PL;
            addr_q    <= 3'd0;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            wdata_q   <= 16'd0;
            ready_q   <= 1'b0;
            tick_q    <= 32'd0;
            active_q  <= '0;
            expired_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            tick_q    <= tick_d;
            active_q  <= active_d;
            expired_q <= expired_d;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign ch_active      = active_q;
    assign ch_expired     = expired_q;
    assign ready          = ready_q;
    assign tick_count     = tick_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_tick_scheduler
// Description : Self-checking bench for timer_tick_scheduler. A scheduling
//               model (edge counts, remaining-tick counters) predicts every
//               output each cycle; literal expectations pin key moments.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       ch_start;
    logic [NUM_CH-1:0]       ch_cancel;
    logic [NUM_CH*CNT_W-1:0] ch_load;
    logic [NUM_CH-1:0]       ch_active;
    logic [NUM_CH-1:0]       ch_expired;
    logic                    ready;
    logic [31:0]             tick_count;
    logic [2:0]              tmr_address;
    logic                    tmr_chipselect;
    logic                    tmr_write_n;
    logic [15:0]             tmr_writedata;
    logic                    tmr_irq;

    always #5 clk = ~clk;

    timer_tick_scheduler #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .TICK_PERIOD (64'd50000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ch_start       (ch_start),
        .ch_cancel      (ch_cancel),
        .ch_load        (ch_load),
        .ch_active      (ch_active),
        .ch_expired     (ch_expired),
        .ready          (ready),
        .tick_count     (tick_count),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model state: edges since reset release, edge of last accepted irq,
    // remaining ticks per channel.
    int          m_n;
    int          m_last;
    int          m_rem [NUM_CH];
    logic [3:0]  m_act;
    logic [3:0]  m_exp;
    logic [31:0] m_tick;
    logic        e_cs;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
    logic        e_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n     = 0;
        m_last  = -100;
        m_act   = '0;
        m_exp   = '0;
        m_tick  = 32'd0;
        e_cs    = 1'b0;
        e_addr  = 3'd0;
        e_data  = 16'd0;
        e_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
    endtask

    task automatic compare_all();
        chk("ch_active",  {28'd0, ch_active},  {28'd0, m_act});
        chk("ch_expired", {28'd0, ch_expired}, {28'd0, m_exp});
        chk("ready",      {31'd0, ready},      {31'd0, e_ready});
        chk("tick_count", tick_count,          m_tick);
        chk("chipselect", {31'd0, tmr_chipselect}, {31'd0, e_cs});
        chk("write_n",    {31'd0, tmr_write_n},    {31'd0, ~e_cs});
        if (e_cs) begin
            chk("address",   {29'd0, tmr_address},   {29'd0, e_addr});
            chk("writedata", {16'd0, tmr_writedata}, {16'd0, e_data});
        end
    endtask

    // One clock: sample inputs, advance model at the edge, compare 1 ns later.
    task automatic step();
        logic [3:0]  st;
        logic [3:0]  cn;
        logic [63:0] ld;
        logic        irq;
        logic        rn;
        bit          tick;
        st  = ch_start;
        cn  = ch_cancel;
        ld  = ch_load;
        irq = tmr_irq;
        rn  = reset_n;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            m_n++;
            tick   = (m_n == m_last + 2);
            e_cs   = 1'b0;
            e_addr = 3'd0;
            e_data = 16'd0;
            if (m_n == 1) begin
                e_cs = 1'b1; e_addr = 3'd2; e_data = 16'hC34F;
            end else if (m_n == 2) begin
                e_cs = 1'b1; e_addr = 3'd3; e_data = 16'h0000;
            end else if (m_n == 3) begin
                e_cs = 1'b1; e_addr = 3'd1; e_data = 16'h0007;
            end else if (m_n >= 4 && m_n >= m_last + 3 && irq) begin
                m_last = m_n;
                e_cs   = 1'b1;
            end
            e_ready = (m_n >= 4);
            if (tick) m_tick++;
            m_exp = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                logic [15:0] l;
                l = ld[i*16 +: 16];
                if (st[i]) begin
                    if (l != 16'd0) begin
                        m_rem[i] = int'(l);
                        m_act[i] = 1'b1;
                    end else begin
                        m_rem[i] = 0;
                        m_act[i] = 1'b0;
                        m_exp[i] = 1'b1;
                    end
                end else if (cn[i]) begin
                    m_act[i] = 1'b0;
                end else if (tick && m_act[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_act[i] = 1'b0;
                        m_exp[i] = 1'b1;
                    end
                end
            end
        end
        #1;
        compare_all();
    endtask

    // irq high for the accept and ACK cycles, dropped before the TICK edge.
    // Returns just after the TICK edge so expiry pulses can be inspected.
    task automatic irq_service();
        tmr_irq = 1'b1;
        step();
        step();
        tmr_irq = 1'b0;
        step();
    endtask

    task automatic start_ch(input int ch, input logic [15:0] load);
        ch_start[ch]           = 1'b1;
        ch_load[ch*16 +: 16]   = load;
    endtask

    task automatic clear_ctl();
        ch_start  = '0;
        ch_cancel = '0;
    endtask

    task automatic check_init_seq();
        step();
        chk("init_pl_addr", {29'd0, tmr_address}, 32'd2);
        chk("init_pl_data", {16'd0, tmr_writedata}, 32'hC34F);
        step();
        chk("init_ph_addr", {29'd0, tmr_address}, 32'd3);
        chk("init_ph_data", {16'd0, tmr_writedata}, 32'h0000);
        step();
        chk("init_ctl_addr", {29'd0, tmr_address}, 32'd1);
        chk("init_ctl_data", {16'd0, tmr_writedata}, 32'h0007);
        chk("ready_low_during_ctl", {31'd0, ready}, 32'd0);
        step();
        chk("ready_high", {31'd0, ready}, 32'd1);
        chk("bus_idle_after_init", {31'd0, tmr_chipselect}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        ch_start  = '0;
        ch_cancel = '0;
        ch_load   = '0;
        tmr_irq   = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_tick", tick_count, 32'd0);
        chk("rst_cs", {31'd0, tmr_chipselect}, 32'd0);
        chk("rst_wn", {31'd0, tmr_write_n}, 32'd1);
        chk("rst_addr", {29'd0, tmr_address}, 32'd0);
        chk("rst_data", {16'd0, tmr_writedata}, 32'd0);
        reset_n = 1'b1;

        // Initialisation writes, then some quiet cycles.
        check_init_seq();
        repeat (3) step();

        // Single irq: one ACK write, tick_count 0 -> 1, no second ACK.
        tmr_irq = 1'b1;
        step();
        chk("ack_cs", {31'd0, tmr_chipselect}, 32'd1);
        chk("ack_addr", {29'd0, tmr_address}, 32'd0);
        chk("ack_data", {16'd0, tmr_writedata}, 32'd0);
        step();
        tmr_irq = 1'b0;
        step();
        chk("tick_after_ack", tick_count, 32'd1);
        repeat (3) step();
        chk("no_second_ack", {31'd0, tmr_chipselect}, 32'd0);

        // Channel 0, load 3, three ticks.
        start_ch(0, 16'd3);
        step();
        clear_ctl();
        irq_service();
        irq_service();
        chk("ch0_active_before_last", {31'd0, ch_active[0]}, 32'd1);
        irq_service();
        chk("ch0_expired", {31'd0, ch_expired[0]}, 32'd1);
        chk("ch0_inactive", {31'd0, ch_active[0]}, 32'd0);
        step();
        chk("ch0_pulse_one_cycle", {31'd0, ch_expired[0]}, 32'd0);

        // Zero load on ch1; start+cancel together on ch2.
        start_ch(1, 16'd0);
        start_ch(2, 16'd5);
        ch_cancel[2] = 1'b1;
        step();
        clear_ctl();
        chk("ch1_zero_expired", {31'd0, ch_expired[1]}, 32'd1);
        chk("ch1_zero_inactive", {31'd0, ch_active[1]}, 32'd0);
        chk("ch2_start_wins", {31'd0, ch_active[2]}, 32'd1);
        step();

        // Channel 3 started in the TICK cycle: no decrement on that tick.
        tmr_irq = 1'b1;
        step();
        step();
        tmr_irq = 1'b0;
        start_ch(3, 16'd2);
        step();
        clear_ctl();
        chk("ch3_active", {31'd0, ch_active[3]}, 32'd1);
        irq_service();
        chk("ch3_not_yet", {31'd0, ch_expired[3]}, 32'd0);
        irq_service();
        chk("ch3_expired", {31'd0, ch_expired[3]}, 32'd1);
        step();

        // Irq still high on return to IDLE starts a new ACK.
        tmr_irq = 1'b1;
        repeat (4) step();
        chk("reack_cs", {31'd0, tmr_chipselect}, 32'd1);
        tmr_irq = 1'b0;
        repeat (3) step();

        // Channel 0 load 4, one tick, then reset mid-operation.
        start_ch(0, 16'd4);
        step();
        clear_ctl();
        irq_service();
        step();
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("midrst_active", {28'd0, ch_active}, 32'd0);
        chk("midrst_tick", tick_count, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        step();
        chk("midrst_no_expire", {28'd0, ch_expired}, 32'd0);
        step();
        reset_n = 1'b1;
        check_init_seq();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
